// File: rtl/lc3b_types.sv
// Shared LC-3b bus types plus the memory responder's FSM state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_responder_state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word-addressed storage: synchronous byte-lane writes, combinational read, no reset.
module mem_responder_array
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  lc3b_mem_wmask        byte_en,
  input  lc3b_word             wdata,
  output lc3b_word             rdata
);

  lc3b_word mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      if (byte_en[0]) mem[addr][7:0]  <= wdata[7:0];
      if (byte_en[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read/write at a time and
// answers with a single-cycle mem_resp LATENCY+1 cycles after acceptance.
module mem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          proto_err
);

  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  mem_responder_state_t state, next_state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] cap_addr, eff_addr;
  lc3b_word             cap_wdata, eff_wdata, arr_rdata;
  lc3b_mem_wmask        cap_be, eff_be;
  logic                 cap_write, eff_write;
  logic                 req, accept, abort, enter_resp, arr_we;
  logic                 addr_unused;

  assign req         = mem_read | mem_write;
  assign addr_unused = mem_address[0] ^ (|(mem_address >> (ADDR_BITS + 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (LATENCY == 0) ? RESP : BUSY;
      BUSY: begin
        if (!req)              next_state = IDLE;
        else if (cnt == '0)    next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY=0 the commit edge is also the acceptance edge, so the
  // live inputs stand in for the not-yet-captured copies while in IDLE.
  always_comb begin
    mem_resp   = (state == RESP);
    accept     = (state == IDLE) && req;
    abort      = (state == BUSY) && !req;
    enter_resp = (next_state == RESP) && (state != RESP);
    eff_addr   = cap_addr;
    eff_wdata  = cap_wdata;
    eff_be     = cap_be;
    eff_write  = cap_write;
    if (state == IDLE) begin
      eff_addr  = mem_address[ADDR_BITS:1];
      eff_wdata = mem_wdata;
      eff_be    = mem_byte_enable;
      eff_write = mem_write;
    end
    arr_we = enter_resp && eff_write && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      cap_write <= 1'b0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= CNT_LOAD;
        cap_addr  <= mem_address[ADDR_BITS:1];
        cap_wdata <= mem_wdata;
        cap_be    <= mem_byte_enable;
        cap_write <= mem_write;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && !eff_write) mem_rdata <= arr_rdata;
      if ((accept && mem_read && mem_write) || abort) proto_err <= 1'b1;
    end
  end

  mem_responder_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk    (clk),
    .we     (arr_we),
    .addr   (eff_addr),
    .byte_en(eff_be),
    .wdata  (eff_wdata),
    .rdata  (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table vectors, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk, rst;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp, proto_err;
  logic [1:0]  mem_byte_enable;

  logic [15:0] z_address, z_wdata, z_rdata;
  logic        z_read, z_write, z_resp, z_perr;
  logic [1:0]  z_be;

  mem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .proto_err(proto_err)
  );

  mem_responder #(.LATENCY(0), .ADDR_BITS(8)) dut0 (
    .clk(clk), .rst(rst), .mem_address(z_address), .mem_read(z_read),
    .mem_write(z_write), .mem_byte_enable(z_be), .mem_wdata(z_wdata),
    .mem_rdata(z_rdata), .mem_resp(z_resp), .proto_err(z_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [15:0] mdl [256];
  logic [15:0] last_rd;
  logic        exp_perr;

  typedef struct {
    int          op;    // 0 read, 1 write, 2 read+write
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] exp;   // expected mem_rdata at the response
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [15:0] addr);
    return (int'(addr) / 2) % 256;
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [1:0] be,
                                      input logic [15:0] wd);
    int i;
    logic [15:0] hi, lo;
    i  = word_of(addr);
    hi = be[1] ? (wd & 16'hFF00) : (mdl[i] & 16'hFF00);
    lo = be[0] ? (wd & 16'h00FF) : (mdl[i] & 16'h00FF);
    mdl[i] = hi | lo;
  endfunction

  task automatic do_op(input int op, input logic [15:0] addr, input logic [1:0] be,
                       input logic [15:0] wd, input bit scramble, input logic [15:0] exp_rd,
                       input string tag);
    int got;
    got = -1;
    @(posedge clk); #1;
    mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    mem_read = (op != 1); mem_write = (op != 0);
    for (int c = 0; c < 20 && got < 0; c++) begin
      @(negedge clk);
      if (mem_resp) got = c;
      else begin
        @(posedge clk); #1;
        if (scramble) begin
          mem_address = 16'($urandom); mem_wdata = 16'($urandom); mem_byte_enable = 2'($urandom);
        end
      end
    end
    chk({tag, "_latency"}, got, LAT + 1);
    chk({tag, "_rdata"}, mem_rdata, exp_rd);
    if (op != 0) model_write(addr, be, wd);
    else         last_rd = exp_rd;
    if (op == 2) exp_perr = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, mem_resp, 1'b0);
    chk({tag, "_proto_err"}, proto_err, exp_perr);
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [4:0]  resp_v;
    logic [7:0]  idx8;
    logic [15:0] a;
    int          r, op;

    tbl.push_back('{1, 16'h0010, 2'b11, 16'hBEEF, 16'h0000});
    tbl.push_back('{0, 16'h0010, 2'b11, 16'h0000, 16'hBEEF});
    tbl.push_back('{1, 16'h0011, 2'b01, 16'h1234, 16'hBEEF});
    tbl.push_back('{0, 16'h0010, 2'b00, 16'h0000, 16'hBE34});
    tbl.push_back('{1, 16'h0202, 2'b11, 16'hAAAA, 16'hBE34});
    tbl.push_back('{0, 16'h0002, 2'b11, 16'h0000, 16'hAAAA});
    tbl.push_back('{0, 16'h0003, 2'b11, 16'h0000, 16'hAAAA});
    tbl.push_back('{1, 16'h0002, 2'b00, 16'hFFFF, 16'hAAAA});
    tbl.push_back('{0, 16'h0202, 2'b11, 16'h0000, 16'hAAAA});
    tbl.push_back('{1, 16'h0020, 2'b11, 16'h0000, 16'hAAAA});
    tbl.push_back('{1, 16'h0004, 2'b11, 16'hCAFE, 16'hAAAA});
    tbl.push_back('{1, 16'h0005, 2'b10, 16'h7700, 16'hAAAA});
    tbl.push_back('{0, 16'h0004, 2'b11, 16'h0000, 16'h77FE});
    tbl.push_back('{0, 16'h0020, 2'b11, 16'h0000, 16'h0000});

    mem_address = '0; mem_wdata = '0; mem_byte_enable = '0; mem_read = 0; mem_write = 0;
    z_address = '0; z_wdata = '0; z_be = '0; z_read = 0; z_write = 0;
    last_rd = '0; exp_perr = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_resp", mem_resp, 1'b0);
    chk("reset_rdata", mem_rdata, 16'h0000);
    chk("reset_proto_err", proto_err, 1'b0);
    chk("reset_lat0_resp", z_resp, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[i]) do_op(tbl[i].op, tbl[i].addr, tbl[i].be, tbl[i].wd, 1'b0, tbl[i].exp,
                           $sformatf("vec%0d", i));

    // Abort: request dropped in the last BUSY cycle, then a fresh read from IDLE.
    chk("abort_perr_before", proto_err, 1'b0);
    @(posedge clk); #1; mem_read = 1'b1; mem_address = 16'h0010;
    @(negedge clk); chk("abort_c0_resp", mem_resp, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_c1_resp", mem_resp, 1'b0);
    @(posedge clk); #1; mem_read = 1'b0;
    @(negedge clk); chk("abort_c2_resp", mem_resp, 1'b0);
    @(posedge clk); #1; mem_read = 1'b1;
    @(negedge clk);
    chk("abort_c3_resp", mem_resp, 1'b0);
    chk("abort_perr_set", proto_err, 1'b1);
    n = 0;
    while (!mem_resp && n < 20) begin @(posedge clk); #1; @(negedge clk); n++; end
    chk("after_abort_latency", n, LAT + 1);
    chk("after_abort_rdata", mem_rdata, 16'hBE34);
    last_rd = 16'hBE34; exp_perr = 1'b1;
    @(posedge clk); #1; mem_read = 1'b0;
    @(negedge clk); chk("after_abort_pulse", mem_resp, 1'b0);

    // Randomized traffic over words 0x40..0x47 with random high/bit0 address bits.
    for (int i = 0; i < 8; i++) begin
      a = {7'($urandom), 8'(8'h40 + i), 1'($urandom)};
      do_op(1, a, 2'b11, 16'($urandom), 1'b0, last_rd, "prefill");
    end
    for (int i = 0; i < 48; i++) begin
      idx8 = 8'h40 + 8'($urandom_range(0, 7));
      a    = {7'($urandom), idx8, 1'($urandom)};
      r    = $urandom_range(0, 4);
      op   = (r < 2) ? 0 : ((r < 4) ? 1 : 2);
      do_op(op, a, 2'($urandom), 16'($urandom), 1'($urandom),
            (op == 0) ? mdl[idx8] : last_rd, "rand");
    end

    // Reset during BUSY of a write: write dropped, no response, outputs cleared at once.
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0020; mem_wdata = 16'h5555; mem_byte_enable = 2'b11;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("rstbusy_resp", mem_resp, 1'b0);
    chk("rstbusy_rdata", mem_rdata, 16'h0000);
    chk("rstbusy_perr", proto_err, 1'b0);
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (mem_resp) seen = 1'b1; end
    chk("rstbusy_no_resp", seen, 1'b0);
    last_rd = 16'h0000; exp_perr = 1'b0;
    do_op(0, 16'h0020, 2'b11, 16'h0000, 1'b0, mdl[16], "rstbusy_readback");
    chk("rstbusy_model", mdl[16], 16'h0000);

    // Simultaneous read and write: treated as a write, error flag sets.
    do_op(2, 16'h0040, 2'b11, 16'h1357, 1'b0, last_rd, "both");
    do_op(0, 16'h0040, 2'b11, 16'h0000, 1'b0, 16'h1357, "both_readback");

    // LATENCY=0: back-to-back read then write, responses in cycles 1 and 3.
    @(posedge clk); #1; z_read = 1'b1; z_address = 16'h0004;
    @(negedge clk); resp_v[0] = z_resp;
    @(posedge clk); #1;
    @(negedge clk); resp_v[1] = z_resp;
    @(posedge clk); #1;
    z_read = 1'b0; z_write = 1'b1; z_address = 16'h0006; z_wdata = 16'h9ABC; z_be = 2'b11;
    @(negedge clk); resp_v[2] = z_resp;
    @(posedge clk); #1;
    @(negedge clk); resp_v[3] = z_resp;
    @(posedge clk); #1; z_write = 1'b0;
    @(negedge clk); resp_v[4] = z_resp;
    chk("lat0_b2b_resp_pattern", resp_v, 5'b01010);
    @(posedge clk); #1; z_read = 1'b1; z_address = 16'h0006;
    @(negedge clk); chk("lat0_read_c0", z_resp, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat0_read_c1", z_resp, 1'b1);
    chk("lat0_read_data", z_rdata, 16'h9ABC);
    @(posedge clk); #1; z_read = 1'b0;
    @(negedge clk);
    chk("lat0_read_pulse", z_resp, 1'b0);
    chk("lat0_perr", z_perr, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
